// File: rtl/darkroom_sensor_hub.sv
// darkroom_sensor_hub: multi-channel lighthouse pulse capture into a shared FIFO drained over Avalon-MM
module darkroom_sensor_hub #(
    parameter int NUM_SENSORS = 16,
    parameter int FIFO_DEPTH  = 64,
    parameter int MIN_PULSE   = 2,
    parameter int MAX_WIDTH   = 511
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [2:0]             address,
    input  logic                   write,
    input  logic [31:0]            writedata,
    input  logic                   read,
    output logic [31:0]            readdata,
    output logic                   waitrequest,
    input  logic [NUM_SENSORS-1:0] sensor_signal_i,
    input  logic [31:0]            timer,
    output logic                   irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = NUM_SENSORS > 1 ? $clog2(NUM_SENSORS) : 1;
    localparam logic [31:0] FILLER = 32'hDEAD_BEEF;

    logic [NUM_SENSORS-1:0] s1, s2, s3, active, en, en_n, pend, ovr, set_ovr, done, rise, fall, clr;
    logic [31:0]            rise_ts [NUM_SENSORS];
    logic [31:0]            width   [NUM_SENSORS];
    logic [26:0]            pend_w  [NUM_SENSORS];
    logic [31:0]            mem     [FIFO_DEPTH];
    logic [AW-1:0]          wp, rp;
    logic [AW:0]            cnt;
    logic [PW-1:0]          rr, gnt;
    logic                   gv, push, pop, full, empty;
    int                     idx;
    logic                   unused;

    assign waitrequest = 1'b0;
    assign unused      = ^writedata;
    assign full        = cnt == (AW+1)'(FIFO_DEPTH);
    assign empty       = cnt == '0;

    // edge detection, pulse qualification and overrun detection per channel
    always_comb begin
        rise    = s2 & ~s3;
        fall    = ~s2 & s3;
        en_n    = (write && address == 3'd2) ? writedata[NUM_SENSORS-1:0] : en;
        done    = '0;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            width[i] = timer - rise_ts[i];
            done[i]  = fall[i] && active[i] && en_n[i] && width[i] >= 32'(MIN_PULSE);
        end
        set_ovr = done & pend;
    end

    // round-robin pick of the first pending channel at or after rr, and FIFO push/pop decisions
    always_comb begin
        gv  = 1'b0;
        gnt = rr;
        idx = 0;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            idx = int'(rr) + i;
            idx = idx >= NUM_SENSORS ? idx - NUM_SENSORS : idx;
            if (!gv && pend[idx]) begin
                gv  = 1'b1;
                gnt = PW'(idx);
            end
        end
        pop  = read && address == 3'd1 && !empty;
        push = gv && (!full || pop);
        clr  = push ? NUM_SENSORS'(1) << gnt : '0;
    end

    // control state: synchronisers, pulse tracking, pending/overrun flags, mask and arbiter pointer
    always_ff @(posedge clock) begin
        if (reset) begin
            s1     <= '0;
            s2     <= '0;
            s3     <= '0;
            active <= '0;
            pend   <= '0;
            ovr    <= '0;
            en     <= '1;
            rr     <= '0;
        end else begin
            s1     <= sensor_signal_i;
            s2     <= s1;
            s3     <= s2;
            en     <= en_n;
            active <= (active | rise) & ~fall & en_n;
            pend   <= (pend & ~clr) | (done & ~pend);
            ovr    <= (ovr & ~((write && address == 3'd3) ? writedata[NUM_SENSORS-1:0] : '0)) | set_ovr;
            if (push) rr <= int'(gnt) == NUM_SENSORS - 1 ? '0 : gnt + 1'b1;
        end
    end

    // datapath storage: rise timestamps, pending words and FIFO memory need no reset
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_SENSORS; i++) begin
            if (rise[i]) rise_ts[i] <= timer;
            if (done[i] && !pend[i]) pend_w[i] <= {width[i] > 32'(MAX_WIDTH) ? 9'(MAX_WIDTH) : width[i][8:0], rise_ts[i][17:0]};
        end
        if (push) mem[wp] <= {5'(gnt), pend_w[gnt]};
    end

    // FIFO pointers, fill count and registered not-empty interrupt
    always_ff @(posedge clock) begin
        if (reset) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
            irq <= 1'b0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
            irq <= cnt != '0;
        end
    end

    // register read mux, combinational on address
    always_comb begin
        readdata = address == 3'd0 ? {16'(cnt), 14'b0, full, empty} :
                   address == 3'd1 ? (empty ? FILLER : mem[rp]) :
                   address == 3'd2 ? 32'(en) :
                   address == 3'd3 ? 32'(ovr) :
                   address == 3'd4 ? {16'(FIFO_DEPTH), 16'(NUM_SENSORS)} : FILLER;
    end
endmodule

// File: tb/tb_darkroom_sensor_hub.sv
// tb_darkroom_sensor_hub: directed table-driven bench for the pulse capture hub
module tb_darkroom_sensor_hub;
    logic        clock = 0, reset = 1, write = 0, read = 0, irq, waitrequest;
    logic [2:0]  address = 0;
    logic [31:0] writedata = 0, readdata, timer = 0, d;
    logic [15:0] sensor_signal_i = 0;
    int          checks = 0, errors = 0;

    typedef struct {
        logic [15:0] m;
        logic [31:0] t1, t2;
        logic        v;
        logic [31:0] w;
    } vec_t;
    vec_t tbl [7];

    darkroom_sensor_hub dut (
        .clock(clock), .reset(reset), .address(address), .write(write), .writedata(writedata),
        .read(read), .readdata(readdata), .waitrequest(waitrequest),
        .sensor_signal_i(sensor_signal_i), .timer(timer), .irq(irq)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] v);
        address = a;
        read = 1;
        #1 v = readdata;
        @(posedge clock);
        #1 read = 0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] v);
        address = a;
        writedata = v;
        write = 1;
        @(posedge clock);
        #1 write = 0;
    endtask

    task automatic pulse(input logic [15:0] m, input logic [31:0] t1, input logic [31:0] t2);
        timer = t1;
        sensor_signal_i = sensor_signal_i | m;
        tick(4);
        timer = t2;
        sensor_signal_i = sensor_signal_i & ~m;
        tick(5);
    endtask

    initial begin
        tbl[0] = '{16'h0008, 32'd1000, 32'd1120, 1'b1, {5'd3, 9'd120, 18'd1000}};
        tbl[1] = '{16'h0001, 32'd50, 32'd51, 1'b0, 32'hDEAD_BEEF};
        tbl[2] = '{16'h0001, 32'd100, 32'd1000, 1'b1, {5'd0, 9'd511, 18'd100}};
        tbl[3] = '{16'h0002, 32'hFFFF_FFF0, 32'h0000_0010, 1'b1, {5'd1, 9'd32, 18'h3FFF0}};
        tbl[4] = '{16'h0080, 32'd200, 32'd202, 1'b1, {5'd7, 9'd2, 18'd200}};
        tbl[5] = '{16'h0004, 32'd10, 32'd521, 1'b1, {5'd2, 9'd511, 18'd10}};
        tbl[6] = '{16'h0010, 32'd10, 32'd522, 1'b1, {5'd4, 9'd511, 18'd10}};
        tick(3);
        reset = 0;
        tick(1);
        rd(0, d); check("reset_status", d, 32'h0000_0001);
        check("reset_irq", {31'b0, irq}, 32'd0);
        rd(2, d); check("reset_mask", d, 32'h0000_FFFF);
        rd(3, d); check("reset_ovr", d, 32'd0);
        check("waitrequest", {31'b0, waitrequest}, 32'd0);
        for (int i = 0; i < 7; i++) begin
            pulse(tbl[i].m, tbl[i].t1, tbl[i].t2);
            rd(0, d); check($sformatf("vec%0d_status", i), d, tbl[i].v ? 32'h0001_0000 : 32'h0000_0001);
            check($sformatf("vec%0d_irq", i), {31'b0, irq}, {31'b0, tbl[i].v});
            rd(1, d); check($sformatf("vec%0d_word", i), d, tbl[i].w);
            tick(2);
        end
        pulse(16'h0020, 32'd0, 32'd10);
        rd(1, d); check("rr_prep", d, {5'd5, 9'd10, 18'd0});
        pulse(16'h0220, 32'd20, 32'd30);
        rd(0, d); check("rr_fill2", d, 32'h0002_0000);
        rd(1, d); check("rr_first_ch9", d, {5'd9, 9'd10, 18'd20});
        rd(1, d); check("rr_second_ch5", d, {5'd5, 9'd10, 18'd20});
        pulse(16'h0050, 32'd40, 32'd45);
        rd(1, d); check("rr_ptr6_ch6", d, {5'd6, 9'd5, 18'd40});
        rd(1, d); check("rr_ptr6_ch4", d, {5'd4, 9'd5, 18'd40});
        for (int i = 0; i < 64; i++) pulse(16'h0002, 32'd0, 32'd3);
        rd(0, d); check("full_status", d, 32'h0040_0002);
        pulse(16'h0004, 32'd100, 32'd110);
        rd(0, d); check("full_held", d, 32'h0040_0002);
        rd(3, d); check("no_ovr_yet", d, 32'd0);
        pulse(16'h0004, 32'd200, 32'd205);
        rd(3, d); check("ovr_set", d, 32'h0000_0004);
        rd(1, d); check("full_pop", d, {5'd1, 9'd3, 18'd0});
        tick(2);
        rd(0, d); check("pending_entered", d, 32'h0040_0002);
        wr(3, 32'h0000_0004);
        rd(3, d); check("ovr_w1c", d, 32'd0);
        for (int i = 0; i < 63; i++) rd(1, d);
        rd(1, d); check("drain_last_ch2", d, {5'd2, 9'd10, 18'd100});
        rd(0, d); check("drained_status", d, 32'h0000_0001);
        wr(2, 32'hFFFF_FFFF);
        rd(2, d); check("mask_upper_zero", d, 32'h0000_FFFF);
        timer = 300;
        sensor_signal_i[8] = 1;
        tick(4);
        wr(2, 32'h0000_FEFF);
        wr(2, 32'h0000_FFFF);
        timer = 400;
        sensor_signal_i[8] = 0;
        tick(5);
        rd(0, d); check("abort_no_word", d, 32'h0000_0001);
        rd(1, d); check("empty_read", d, 32'hDEAD_BEEF);
        rd(0, d); check("empty_fill0", d, 32'h0000_0001);
        rd(4, d); check("const_reg", d, 32'h0040_0010);
        rd(5, d); check("addr5", d, 32'hDEAD_BEEF);
        rd(7, d); check("addr7", d, 32'hDEAD_BEEF);
        wr(0, 32'h1234_5678);
        rd(0, d); check("ro_write_ignored", d, 32'h0000_0001);
        wr(2, 32'h0000_00FF);
        timer = 500;
        sensor_signal_i[3] = 1;
        tick(4);
        reset = 1;
        tick(2);
        sensor_signal_i[3] = 0;
        tick(3);
        reset = 0;
        timer = 600;
        tick(6);
        rd(0, d); check("reset_mid_no_word", d, 32'h0000_0001);
        check("reset_mid_irq", {31'b0, irq}, 32'd0);
        rd(2, d); check("reset_mid_mask", d, 32'h0000_FFFF);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
